// File: rtl/ip_header_tx.sv
// IPv4 header builder: latches a descriptor, emits a 20-byte header, then passes the payload.
// Define IP_HEADER_TX_CHECKSUM_EN to compute the header checksum internally.
module ip_header_tx (
   input  logic        clk,
   input  logic        rst,
   input  logic        hdr_valid,
   output logic        hdr_ready,
   input  logic [5:0]  dscp,
   input  logic [1:0]  ecn,
   input  logic [15:0] payload_length,
   input  logic [15:0] identification,
   input  logic [2:0]  flags,
   input  logic [12:0] fragment_offset,
   input  logic [7:0]  ttl,
   input  logic [7:0]  protocol,
   input  logic [15:0] header_checksum,
   input  logic [31:0] source_ip,
   input  logic [31:0] dest_ip,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast
);

`ifdef IP_HEADER_TX_CHECKSUM_EN
   typedef enum logic [2:0] {StIdle, StSum, StFold, StHeader, StPayload} state_t;
`else
   typedef enum logic [2:0] {StIdle, StHeader, StPayload} state_t;
`endif

   state_t      state;
   logic [5:0]  dscp_q;
   logic [1:0]  ecn_q;
   logic [15:0] plen_q;
   logic [15:0] id_q;
   logic [2:0]  flags_q;
   logic [12:0] frag_q;
   logic [7:0]  ttl_q;
   logic [7:0]  proto_q;
   logic [31:0] src_q;
   logic [31:0] dst_q;
   logic [15:0] csum_q;
   logic [4:0]  cnt_q;
   logic [7:0]  out_data_q;
   logic        out_valid_q;
   logic        out_last_q;

   logic [15:0] total_len;
   logic [4:0]  nxt_idx;
   logic [7:0]  nxt_byte;

   assign total_len = plen_q + 16'd20;
   assign nxt_idx   = cnt_q + 5'd1;
   assign hdr_ready = (state == StIdle);

`ifdef IP_HEADER_TX_CHECKSUM_EN
   logic [19:0] acc_q;
   logic [19:0] sum_w;
   logic [16:0] fold1;
   logic [15:0] fold2;
   logic        unused_hdr_checksum;

   assign unused_hdr_checksum = ^header_checksum;

   // Checksum word itself is taken as zero, so it is simply left out of the sum.
   always_comb begin
      sum_w = {4'b0, 8'h45, dscp_q, ecn_q}
            + {4'b0, total_len}
            + {4'b0, id_q}
            + {4'b0, flags_q, frag_q}
            + {4'b0, ttl_q, proto_q}
            + {4'b0, src_q[31:16]}
            + {4'b0, src_q[15:0]}
            + {4'b0, dst_q[31:16]}
            + {4'b0, dst_q[15:0]};
   end

   assign fold1 = {1'b0, acc_q[15:0]} + {13'b0, acc_q[19:16]};
   assign fold2 = fold1[15:0] + {15'b0, fold1[16]};
`endif

   always_comb begin
      nxt_byte = 8'h00;
      case (nxt_idx)
         5'd1:    nxt_byte = {dscp_q, ecn_q};
         5'd2:    nxt_byte = total_len[15:8];
         5'd3:    nxt_byte = total_len[7:0];
         5'd4:    nxt_byte = id_q[15:8];
         5'd5:    nxt_byte = id_q[7:0];
         5'd6:    nxt_byte = {flags_q, frag_q[12:8]};
         5'd7:    nxt_byte = frag_q[7:0];
         5'd8:    nxt_byte = ttl_q;
         5'd9:    nxt_byte = proto_q;
         5'd10:   nxt_byte = csum_q[15:8];
         5'd11:   nxt_byte = csum_q[7:0];
         5'd12:   nxt_byte = src_q[31:24];
         5'd13:   nxt_byte = src_q[23:16];
         5'd14:   nxt_byte = src_q[15:8];
         5'd15:   nxt_byte = src_q[7:0];
         5'd16:   nxt_byte = dst_q[31:24];
         5'd17:   nxt_byte = dst_q[23:16];
         5'd18:   nxt_byte = dst_q[15:8];
         5'd19:   nxt_byte = dst_q[7:0];
         default: nxt_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= StIdle;
         dscp_q      <= '0;
         ecn_q       <= '0;
         plen_q      <= '0;
         id_q        <= '0;
         flags_q     <= '0;
         frag_q      <= '0;
         ttl_q       <= '0;
         proto_q     <= '0;
         src_q       <= '0;
         dst_q       <= '0;
         csum_q      <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
`ifdef IP_HEADER_TX_CHECKSUM_EN
         acc_q       <= '0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               if (hdr_valid) begin
                  dscp_q  <= dscp;
                  ecn_q   <= ecn;
                  plen_q  <= payload_length;
                  id_q    <= identification;
                  flags_q <= flags;
                  frag_q  <= fragment_offset;
                  ttl_q   <= ttl;
                  proto_q <= protocol;
                  src_q   <= source_ip;
                  dst_q   <= dest_ip;
                  cnt_q   <= '0;
`ifdef IP_HEADER_TX_CHECKSUM_EN
                  state   <= StSum;
`else
                  csum_q      <= header_checksum;
                  out_data_q  <= 8'h45;
                  out_valid_q <= 1'b1;
                  out_last_q  <= 1'b0;
                  state       <= StHeader;
`endif
               end
            end
`ifdef IP_HEADER_TX_CHECKSUM_EN
            StSum: begin
               acc_q <= sum_w;
               state <= StFold;
            end
            StFold: begin
               csum_q      <= ~fold2;
               out_data_q  <= 8'h45;
               out_valid_q <= 1'b1;
               out_last_q  <= 1'b0;
               state       <= StHeader;
            end
`endif
            StHeader: begin
               // out_valid_q is always high here, so tready alone completes a beat.
               if (m_axis_tready) begin
                  if (cnt_q == 5'd19) begin
                     cnt_q       <= '0;
                     out_data_q  <= '0;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     state       <= (plen_q == 16'd0) ? StIdle : StPayload;
                  end else begin
                     cnt_q      <= nxt_idx;
                     out_data_q <= nxt_byte;
                     out_last_q <= (nxt_idx == 5'd19) && (plen_q == 16'd0);
                  end
               end
            end
            StPayload: begin
               if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   always_comb begin
      if (state == StPayload) begin
         m_axis_tdata  = s_axis_tdata;
         m_axis_tvalid = s_axis_tvalid;
         m_axis_tlast  = s_axis_tlast;
         s_axis_tready = m_axis_tready;
      end else begin
         m_axis_tdata  = out_data_q;
         m_axis_tvalid = out_valid_q;
         m_axis_tlast  = out_last_q;
         s_axis_tready = 1'b0;
      end
   end

endmodule
